// File: rtl/demultiplexer_1_4_4bit_seq.sv
// Registered 1-to-4 demultiplexer: steers one shared bus word into one of four held
// output registers, either by caller-supplied slot (direct) or by an internal round-robin pointer.
module demultiplexer_1_4_4bit_seq #(
    parameter int WIDTH  = 4,
    parameter int FCNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [1:0]        in_sel,
    input  logic              rr_mode,
    input  logic              hold,
    input  logic              clear,
    output logic [WIDTH-1:0]  out_0,
    output logic [WIDTH-1:0]  out_1,
    output logic [WIDTH-1:0]  out_2,
    output logic [WIDTH-1:0]  out_3,
    output logic [3:0]        out_load,
    output logic              frame_done,
    output logic [1:0]        slot,
    output logic [FCNT_W-1:0] frame_count
);

    logic [WIDTH-1:0] regs_q [4];
    logic             rr_mode_q;
    logic             xfer;
    logic             mode_change;
    logic [1:0]       base_slot;
    logic [1:0]       target;

    assign in_ready = ~hold & ~clear & ~reset;

    // A mode flip restarts the pointer on this same edge, so a round-robin
    // transfer coincident with the flip lands in slot 0.
    always_comb begin
        xfer        = in_valid & in_ready;
        mode_change = rr_mode ^ rr_mode_q;
        base_slot   = mode_change ? 2'd0 : slot;
        target      = rr_mode ? base_slot : in_sel;
    end

    // NOTE: state updates use <= so every register samples pre-edge values;
    // the output registers are reset explicitly because their zero value is observable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) regs_q[k] <= '0;
            rr_mode_q   <= 1'b0;
            out_load    <= '0;
            frame_done  <= 1'b0;
            slot        <= 2'd0;
            frame_count <= '0;
        end else begin
            rr_mode_q  <= rr_mode;
            out_load   <= '0;
            frame_done <= 1'b0;
            if (clear) begin
                for (int k = 0; k < 4; k++) regs_q[k] <= '0;
                slot <= 2'd0;
            end else begin
                slot <= base_slot;
                // in_data/in_sel only reach state under xfer, so X on them is harmless otherwise.
                if (xfer) begin
                    regs_q[target] <= in_data;
                    out_load       <= 4'b0001 << target;
                    if (rr_mode) begin
                        slot <= base_slot + 2'd1;
                        if (base_slot == 2'd3) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + FCNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign out_0 = regs_q[0];
    assign out_1 = regs_q[1];
    assign out_2 = regs_q[2];
    assign out_3 = regs_q[3];

endmodule

// File: tb/tb_demultiplexer_1_4_4bit_seq.sv
// Self-checking bench for demultiplexer_1_4_4bit_seq: directed scenarios plus a
// randomized run, all compared against a slot-array/pointer reference model.
module tb_demultiplexer_1_4_4bit_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'h0;
    logic [1:0] in_sel = 2'd0;
    logic       rr_mode = 1'b0;
    logic       hold = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] out_0, out_1, out_2, out_3;
    logic [3:0] out_load;
    logic       frame_done;
    logic [1:0] slot;
    logic [3:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0] exp_out [4];
    logic [3:0] exp_load;
    logic       exp_fd;
    int         exp_slot;
    int         exp_fc;
    logic       exp_mode_q;

    demultiplexer_1_4_4bit_seq #(.WIDTH(4), .FCNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .rr_mode(rr_mode), .hold(hold),
        .clear(clear), .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
        .out_load(out_load), .frame_done(frame_done), .slot(slot),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] s,
                         input logic m, input logic h, input logic c, input logic r);
        in_valid = v; in_data = d; in_sel = s; rr_mode = m; hold = h; clear = c; reset = r;
    endtask

    // Advance the model by one edge from the currently driven inputs, then let the DUT take the edge.
    task automatic tick();
        int t;
        exp_load = 4'b0000;
        exp_fd   = 1'b0;
        if (reset) begin
            for (int k = 0; k < 4; k++) exp_out[k] = 4'h0;
            exp_slot = 0; exp_fc = 0; exp_mode_q = 1'b0;
        end else begin
            if (clear) begin
                for (int k = 0; k < 4; k++) exp_out[k] = 4'h0;
                exp_slot = 0;
            end else begin
                if (rr_mode != exp_mode_q) exp_slot = 0;
                if (in_valid && !hold) begin
                    t = rr_mode ? exp_slot : int'(in_sel);
                    exp_out[t] = in_data;
                    exp_load   = 4'(1 << t);
                    if (rr_mode) begin
                        if (exp_slot == 3) begin
                            exp_fd = 1'b1;
                            exp_fc = (exp_fc + 1) % 16;
                        end
                        exp_slot = (exp_slot + 1) % 4;
                    end
                end
            end
            exp_mode_q = rr_mode;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'h3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", in_ready); end
        tick();
        n_checks++;
        if ({out_3, out_2, out_1, out_0} !== 16'h0000 || out_load !== 4'b0 || frame_done !== 1'b0
            || slot !== 2'd0 || frame_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%h/%b/%b/%0d/%0d want=0", {out_3, out_2, out_1, out_0},
                     out_load, frame_done, slot, frame_count);
        end
        drive(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_direct();
        logic [3:0] d [3] = '{4'hA, 4'h5, 4'hF};
        logic [1:0] s [3] = '{2'd2, 2'd0, 2'd3};
        logic [3:0] l [3] = '{4'b0100, 4'b0001, 4'b1000};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, d[i], s[i], 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            n_checks++;
            if (out_load !== l[i] || frame_done !== 1'b0) begin
                n_fail++; $display("FAIL direct_load[%0d] got=%b fd=%b want=%b fd=0", i, out_load, frame_done, l[i]);
            end
        end
        drive(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({out_3, out_2, out_1, out_0} !== 16'hFA05 || out_load !== 4'b0) begin
            n_fail++; $display("FAIL direct_values got=%h load=%b want=fa05 load=0000", {out_3, out_2, out_1, out_0}, out_load);
        end
    endtask

    task automatic test_rr_frame();
        int fd_seen = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i + 1), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (i > 0 && slot !== 2'(i)) begin
                n_fail++; $display("FAIL rr_slot[%0d] got=%0d want=%0d", i, slot, i);
            end
            tick();
        end
        n_checks++;
        if ({out_3, out_2, out_1, out_0} !== 16'h4321 || slot !== 2'd0 || frame_done !== 1'b1
            || out_load !== 4'b1000 || frame_count !== 4'd1) begin
            n_fail++;
            $display("FAIL rr_frame got=%h slot=%0d fd=%b load=%b fc=%0d want=4321 slot=0 fd=1 load=1000 fc=1",
                     {out_3, out_2, out_1, out_0}, slot, frame_done, out_load, frame_count);
        end
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 4'($urandom), 2'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            if (frame_done === 1'b1) fd_seen++;
        end
        n_checks++;
        if (frame_count !== 4'd1 || fd_seen != 16 || frame_count !== 4'(exp_fc)) begin
            n_fail++; $display("FAIL rr_wrap fc=%0d pulses=%0d want fc=1 pulses=16", frame_count, fd_seen);
        end
    endtask

    task automatic test_hold();
        logic [15:0] snap;
        int writes = 0;
        int tgt;
        drive(1'b1, 4'h9, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        snap = {out_3, out_2, out_1, out_0};
        tgt  = exp_slot;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d] got=%b want=0", i, in_ready); end
            tick();
            n_checks++;
            if ({out_3, out_2, out_1, out_0} !== snap || out_load !== 4'b0) begin
                n_fail++; $display("FAIL hold_frozen[%0d] got=%h load=%b want=%h load=0000", i, {out_3, out_2, out_1, out_0}, out_load, snap);
            end
        end
        hold = 1'b0;
        tick();
        if (out_load !== 4'b0) writes++;
        n_checks++;
        if (out_load !== 4'(1 << tgt) || exp_out[tgt] !== 4'h9 || {out_3, out_2, out_1, out_0}
            !== {exp_out[3], exp_out[2], exp_out[1], exp_out[0]}) begin
            n_fail++; $display("FAIL hold_release load=%b want=%b", out_load, 4'(1 << tgt));
        end
        in_valid = 1'b0;
        tick();
        if (out_load !== 4'b0) writes++;
        n_checks++;
        if (writes != 1) begin n_fail++; $display("FAIL hold_single_write got=%0d want=1", writes); end
    endtask

    task automatic test_clear();
        int fc_before;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i + 1), 2'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        fc_before = exp_fc;
        drive(1'b1, 4'h7, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready got=%b want=0", in_ready); end
        tick();
        n_checks++;
        if ({out_3, out_2, out_1, out_0} !== 16'h0 || out_load !== 4'b0 || slot !== 2'd0
            || frame_count !== 4'(fc_before)) begin
            n_fail++; $display("FAIL clear_state got=%h load=%b slot=%0d fc=%0d want=0 0000 0 %0d",
                               {out_3, out_2, out_1, out_0}, out_load, slot, frame_count, fc_before);
        end
        drive(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({out_3, out_2, out_1, out_0} !== 16'h0) begin
            n_fail++; $display("FAIL clear_not_consumed got=%h want=0000", {out_3, out_2, out_1, out_0});
        end
    endtask

    task automatic test_mode_switch();
        int fc_before = exp_fc;
        int fd_seen = 0;
        drive(1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick(); fd_seen += int'(frame_done);
        drive(1'b1, 4'h2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick(); fd_seen += int'(frame_done);
        n_checks++;
        if (slot !== 2'd2) begin n_fail++; $display("FAIL switch_slot2 got=%0d want=2", slot); end
        drive(1'b1, 4'hC, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0); tick(); fd_seen += int'(frame_done);
        drive(1'b1, 4'hE, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0); tick(); fd_seen += int'(frame_done);
        n_checks++;
        if (out_3 !== 4'hC || out_0 !== 4'hE || out_1 !== 4'h2 || slot !== 2'd1 || fd_seen != 0
            || frame_count !== 4'(fc_before)) begin
            n_fail++; $display("FAIL switch_result out3=%h out0=%h out1=%h slot=%0d fd=%0d fc=%0d want C E 2 1 0 %0d",
                               out_3, out_0, out_1, slot, fd_seen, frame_count, fc_before);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'h6, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 4'h8, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 4'hB, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ready got=%b want=0", in_ready); end
        tick();
        n_checks++;
        if ({out_3, out_2, out_1, out_0} !== 16'h0 || slot !== 2'd0 || out_load !== 4'b0
            || frame_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid_state got=%h slot=%0d load=%b fc=%0d want=0",
                               {out_3, out_2, out_1, out_0}, slot, out_load, frame_count);
        end
        drive(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
            #1;
            n_checks++;
            if (in_ready !== (!hold && !clear && !reset)) begin
                n_fail++; $display("FAIL rand_ready[%0d] got=%b", i, in_ready);
            end
            tick();
            n_checks++;
            if ({out_3, out_2, out_1, out_0} !== {exp_out[3], exp_out[2], exp_out[1], exp_out[0]}
                || out_load !== exp_load || frame_done !== exp_fd || slot !== 2'(exp_slot)
                || frame_count !== 4'(exp_fc)) begin
                n_fail++;
                $display("FAIL rand_state[%0d] got=%h/%b/%b/%0d/%0d want=%h/%b/%b/%0d/%0d", i,
                         {out_3, out_2, out_1, out_0}, out_load, frame_done, slot, frame_count,
                         {exp_out[3], exp_out[2], exp_out[1], exp_out[0]}, exp_load, exp_fd, exp_slot, exp_fc);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_direct();
        test_rr_frame();
        test_hold();
        test_clear();
        test_mode_switch();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demultiplexer_1_4_4bit_seq.md
Name: demultiplexer_1_4_4bit_seq

Overview:
Registered 1-to-4 demultiplexer for the 4-bit datapath. It is the distributing counterpart of the 2:1 / 4-bit multiplexers: it takes one shared 4-bit bus value and steers it into one of four held output registers. Two steering modes are supported:
- Direct: the caller supplies the slot number.
- Round-robin: an internal slot counter fills slots 0..3 in order and reports frame completion.
Transfers use a valid/ready handshake. The block sits between the shared bus and the per-unit operand latches.

Parameters:
WIDTH, 4, data width of the bus and of each output register
FCNT_W, 4, width of the completed-frame counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  bus word present
in_ready  output  1  block can accept a word this cycle (combinational)
in_data  input  WIDTH  bus word
in_sel  input  2  target slot in direct mode; ignored in round-robin mode
rr_mode  input  1  0 = direct, 1 = round-robin
hold  input  1  freeze outputs and refuse transfers
clear  input  1  synchronous clear of all output registers
out_0  output  WIDTH  slot 0 register
out_1  output  WIDTH  slot 1 register
out_2  output  WIDTH  slot 2 register
out_3  output  WIDTH  slot 3 register
out_load  output  4  one-hot, one-cycle pulse marking the slot updated
frame_done  output  1  one-cycle pulse when round-robin slot 3 is written
slot  output  2  current round-robin slot pointer
frame_count  output  FCNT_W  number of completed round-robin frames

Behaviour:
- Reset (synchronous, highest priority): out_0..out_3 = 0, out_load = 0, frame_done = 0, slot = 0, frame_count = 0, internal rr_mode_q = 0.
- in_ready = ~hold & ~clear & ~reset. This is purely combinational, with no dependence on in_valid.
- A transfer occurs on a rising edge when in_valid & in_ready.
- Target slot on a transfer: in_sel when rr_mode = 0; slot when rr_mode = 1.
- Latency: the target register holds in_data in the cycle after the transfer edge. out_load[target] = 1 in that same cycle only. Other registers are unchanged.
- No transfer in a cycle: out_load = 0 and frame_done = 0 on the next cycle. Registers keep their values. hold never alters register contents.
- clear = 1 (below reset, above transfer): all out_k = 0 next cycle, out_load = 0, slot = 0. frame_count is unchanged. No transfer happens because in_ready = 0.
- Round-robin pointer:
  - On each round-robin transfer, slot increments, wrapping 3 -> 0.
  - On a round-robin transfer with slot = 3: frame_done = 1 next cycle (coincident with out_load[3]), and frame_count increments, wrapping 2^FCNT_W-1 -> 0.
- Mode change: rr_mode_q registers rr_mode every cycle.
  - If rr_mode != rr_mode_q, slot is forced to 0 this edge (abandoning any partial frame, no frame_done).
  - A transfer on that same edge still occurs. Its target follows the new rr_mode; in round-robin mode it targets slot 0 and slot becomes 1.
- Direct-mode transfers never touch slot, frame_done, or frame_count.
- Back-to-back transfers every cycle are supported at full rate. The same slot may be written on consecutive cycles; the last write wins.
- in_data and in_sel are sampled only on transfer edges. No X-propagation is allowed from them otherwise.

Test Plan:
1. Reset then direct writes. Stimulus: rr_mode = 0; (sel 2, 0xA), (sel 0, 0x5), (sel 3, 0xF) on consecutive cycles. Required: out_2 = A, out_0 = 5, out_3 = F, out_1 = 0. out_load sequence is 0100, 0001, 1000, each one cycle after its transfer. frame_done never asserts.
2. Round-robin frame. Stimulus: rr_mode = 1; data 1, 2, 3, 4 back-to-back. Required: out_0..3 = 1, 2, 3, 4; slot sequence 0, 1, 2, 3, 0; frame_done pulses once with out_load = 1000; frame_count = 1. Run 16 more frames: frame_count wraps to 1.
3. Hold backpressure. Stimulus: round-robin, in_valid held high with data 9, hold = 1 for 3 cycles then 0. Required: in_ready = 0 and no register change during hold. Exactly one write of 9 to the current slot after hold drops.
4. Clear versus transfer. Stimulus: all slots loaded with nonzero values; clear = 1 with in_valid = 1, data 7. Required: all outputs 0, out_load = 0, slot = 0, frame_count unchanged, word 7 not consumed.
5. Mode switch mid-frame. Stimulus: round-robin writes 1, 2 (slot = 2), then rr_mode = 0 with (sel 3, 0xC), then rr_mode = 1 with data 0xE. Required: out_3 = C; out_0 = E (slot restarted at 0); no frame_done; frame_count unchanged.
6. Reset mid-frame. Stimulus: reset asserted after 2 round-robin writes, coincident with in_valid = 1. Required: all outputs 0 next cycle, in_ready = 0 during reset, slot = 0.
